// File: rtl/mem_access_stage.sv
// Memory-access stage of the 16-bit pipeline.
// Converts MemEN loads/stores into a req/ack transaction with a variable-latency
// data memory, stalls the pipeline while the access is outstanding, and latches HALT.
// Optional feature: define MEM_ALIGN_CHECK_EN to reject odd addresses (sticky err).
module mem_access_stage #(
    parameter int unsigned ADDR_W = 16,
    parameter int unsigned DATA_W = 16
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              MemEN,
    input  logic              MemWrite,
    input  logic              Halt,
    input  logic [ADDR_W-1:0] addr,
    input  logic [DATA_W-1:0] wrData,
    output logic              memReq,
    output logic              memWr,
    output logic [ADDR_W-1:0] memAddr,
    output logic [DATA_W-1:0] memWData,
    input  logic [DATA_W-1:0] memRData,
    input  logic              memAck,
    output logic [DATA_W-1:0] dataMemOut,
    output logic              stall,
    output logic              memDone,
    output logic              HaltOut,
    output logic              err
);

    typedef enum logic [1:0] {StIdle, StAccess, StDone, StHalted} state_e;

    state_e            r_state;
    logic              r_req;
    logic              r_wr;
    logic [ADDR_W-1:0] r_addr;
    logic [DATA_W-1:0] r_wdata;
    logic [DATA_W-1:0] r_dout;
    logic              r_done;
    logic              r_halt;
    logic              r_err;
    logic              w_misaligned;
    logic              w_stall;

`ifdef MEM_ALIGN_CHECK_EN
    assign w_misaligned = addr[0];
`else
    assign w_misaligned = 1'b0;
`endif

    // Access FSM with all memory-side and status outputs registered.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_state <= StIdle;
            r_req   <= 1'b0;
            r_wr    <= 1'b0;
            r_addr  <= '0;
            r_wdata <= '0;
            r_dout  <= '0;
            r_done  <= 1'b0;
            r_halt  <= 1'b0;
            r_err   <= 1'b0;
        end else begin
            r_done <= 1'b0;
            unique case (r_state)
                StIdle: begin
                    if (Halt) begin
                        // HALT wins over a simultaneous memory access
                        r_state <= StHalted;
                        r_halt  <= 1'b1;
                    end else if (MemEN) begin
                        if (w_misaligned) begin
                            // Retire without touching memory; loads return zero
                            r_state <= StDone;
                            r_done  <= 1'b1;
                            r_err   <= 1'b1;
                            if (!MemWrite) begin
                                r_dout <= '0;
                            end
                        end else begin
                            r_state <= StAccess;
                            r_req   <= 1'b1;
                            r_wr    <= MemWrite;
                            r_addr  <= addr;
                            r_wdata <= wrData;
                        end
                    end
                end
                StAccess: begin
                    if (memAck) begin
                        r_req   <= 1'b0;
                        r_state <= StDone;
                        r_done  <= 1'b1;
                        if (!r_wr) begin
                            r_dout <= memRData;
                        end
                    end
                end
                StDone: begin
                    // Same instruction is still on the inputs, so ignore them
                    r_state <= StIdle;
                end
                StHalted: begin
                    r_state <= StHalted;
                end
                default: begin
                    r_state <= StIdle;
                end
            endcase
        end
    end

    // Stall decode: from state, MemEN and Halt only (never from memAck).
    always_comb begin
        w_stall = 1'b0;
        case (r_state)
            StIdle:   w_stall = MemEN & ~Halt;
            StAccess: w_stall = 1'b1;
            default:  w_stall = 1'b0;
        endcase
    end

    // Outputs held at zero while reset is asserted.
    assign stall      = w_stall & rst;
    assign memReq     = r_req;
    assign memWr      = r_wr;
    assign memAddr    = r_addr;
    assign memWData   = r_wdata;
    assign dataMemOut = r_dout;
    assign memDone    = r_done;
    assign HaltOut    = r_halt;
    assign err        = r_err;

endmodule

// File: tb/tb_mem_access_stage.sv
// Self-checking bench for mem_access_stage: transaction-level reference model
// (stall count, request count, load result, sticky err) with random stimulus.
module tb_mem_access_stage;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic        MemEN = 1'b0;
    logic        MemWrite = 1'b0;
    logic        Halt = 1'b0;
    logic [15:0] addr = '0;
    logic [15:0] wrData = '0;
    logic [15:0] memRData = '0;
    logic        memAck = 1'b0;
    logic        memReq;
    logic        memWr;
    logic [15:0] memAddr;
    logic [15:0] memWData;
    logic [15:0] dataMemOut;
    logic        stall;
    logic        memDone;
    logic        HaltOut;
    logic        err;

    int          checks = 0;
    int          errors = 0;
    int          cyc_cnt = 0;
    logic [15:0] exp_dout = '0;
    logic        exp_err = 1'b0;

    mem_access_stage #(.ADDR_W(16), .DATA_W(16)) dut (
        .clk        (clk),
        .rst        (rst),
        .MemEN      (MemEN),
        .MemWrite   (MemWrite),
        .Halt       (Halt),
        .addr       (addr),
        .wrData     (wrData),
        .memReq     (memReq),
        .memWr      (memWr),
        .memAddr    (memAddr),
        .memWData   (memWData),
        .memRData   (memRData),
        .memAck     (memAck),
        .dataMemOut (dataMemOut),
        .stall      (stall),
        .memDone    (memDone),
        .HaltOut    (HaltOut),
        .err        (err)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc_cnt <= cyc_cnt + 1;

    // Runs one access from the IDLE cycle through DONE; starts and ends at posedge+1.
    task automatic run_access(input logic wr, input logic [15:0] a, input logic [15:0] d,
                              input logic [15:0] rd, input int w, output int req_start);
        int stall_n = 0;
        int req_n = 0;
        int n = 0;
        bit done = 0;
        bit mis;
`ifdef MEM_ALIGN_CHECK_EN
        mis = a[0];
`else
        mis = 1'b0;
`endif
        req_start = -1;
        MemEN = 1'b1; MemWrite = wr; addr = a; wrData = d; memRData = rd; Halt = 1'b0;
        while (!done && n < 40) begin
            memAck = (memReq === 1'b1 && req_n == w);
            @(negedge clk);
            if (stall === 1'b1) stall_n++;
            if (memReq === 1'b1) begin
                if (req_n == 0) req_start = cyc_cnt;
                req_n++;
                checks++;
                if (memAddr !== a || memWr !== wr || (wr && memWData !== d)) begin
                    errors++;
                    $display("FAIL req_fields: got addr=%h wr=%b wdata=%h, want addr=%h wr=%b wdata=%h",
                             memAddr, memWr, memWData, a, wr, d);
                end
            end
            if (memDone === 1'b1) done = 1;
            @(posedge clk); #1;
            n++;
        end
        MemEN = 1'b0; memAck = 1'b0;
        if (mis) begin
            exp_err = 1'b1;
            if (!wr) exp_dout = '0;
        end else if (!wr) begin
            exp_dout = rd;
        end
        checks++;
        if (!done) begin
            errors++;
            $display("FAIL done_timeout: memDone not seen within %0d cycles, want pulse", n);
        end
        checks++;
        if (stall_n != (mis ? 1 : 2 + w)) begin
            errors++;
            $display("FAIL stall_cycles: got %0d, want %0d", stall_n, mis ? 1 : 2 + w);
        end
        checks++;
        if (req_n != (mis ? 0 : w + 1)) begin
            errors++;
            $display("FAIL req_cycles: got %0d, want %0d", req_n, mis ? 0 : w + 1);
        end
        checks++;
        if (dataMemOut !== exp_dout) begin
            errors++;
            $display("FAIL data_out: got %h, want %h", dataMemOut, exp_dout);
        end
        checks++;
        if (err !== exp_err) begin
            errors++;
            $display("FAIL err_flag: got %b, want %b", err, exp_err);
        end
    endtask

    task automatic apply_reset();
        rst = 1'b0; MemEN = 1'b0; Halt = 1'b0; memAck = 1'b0;
        exp_dout = '0; exp_err = 1'b0;
        repeat (2) @(posedge clk);
        @(negedge clk) rst = 1'b1;
        @(posedge clk); #1;
    endtask

    task automatic test_reset();
        rst = 1'b0;
        repeat (4) begin
            @(posedge clk); #1;
            MemEN = 1'($urandom); Halt = 1'($urandom); MemWrite = 1'($urandom);
            addr = 16'($urandom); wrData = 16'($urandom); memRData = 16'($urandom);
            memAck = 1'($urandom);
            @(negedge clk);
            checks++;
            if ({memReq, memWr, memAddr, memWData, dataMemOut, stall, memDone, HaltOut, err} !== '0) begin
                errors++;
                $display("FAIL reset_outputs: req=%b wr=%b addr=%h wd=%h dout=%h stall=%b done=%b halt=%b err=%b, want all 0",
                         memReq, memWr, memAddr, memWData, dataMemOut, stall, memDone, HaltOut, err);
            end
        end
        @(posedge clk); #1;
        MemEN = 0; Halt = 0; MemWrite = 0; memAck = 0; addr = 0; wrData = 0;
        #2 rst = 1'b1;
        @(negedge clk);
        checks++;
        if (stall !== 1'b0 || memReq !== 1'b0) begin
            errors++;
            $display("FAIL reset_release: stall=%b req=%b, want 0 0", stall, memReq);
        end
        @(posedge clk); #1;
    endtask

    task automatic test_zero_wait_load();
        int s;
        run_access(1'b0, 16'h0010, 16'h0000, 16'hBEEF, 0, s);
    endtask

    task automatic test_store_then_load();
        int s1, s2;
        run_access(1'b1, 16'h0020, 16'h1234, 16'h5A5A, 3, s1);
        run_access(1'b0, 16'h0020, 16'h0000, 16'h1234, 1, s2);
        checks++;
        if (s2 - s1 < 3) begin
            errors++;
            $display("FAIL store_load_spacing: got %0d cycles, want >= 3", s2 - s1);
        end
    endtask

    task automatic test_misaligned();
        int s;
        run_access(1'b0, 16'h0040, 16'h0000, 16'hCAFE, 0, s);
        run_access(1'b0, 16'h0011, 16'h0000, 16'hA5A5, 0, s);
        run_access(1'b1, 16'h0013, 16'h7777, 16'h0000, 1, s);
        run_access(1'b0, 16'h0050, 16'h0000, 16'h4242, 2, s);
    endtask

    task automatic test_random();
        int s;
        for (int i = 0; i < 24; i++) begin
            run_access(1'($urandom), 16'($urandom), 16'($urandom), 16'($urandom),
                       int'($urandom_range(0, 4)), s);
            // Idle gap with stray acks that must be ignored
            for (int k = 0; k < int'($urandom_range(0, 2)); k++) begin
                memAck = 1'($urandom); memRData = 16'($urandom);
                @(negedge clk);
                checks++;
                if (memDone !== 1'b0 || stall !== 1'b0 || dataMemOut !== exp_dout) begin
                    errors++;
                    $display("FAIL idle_ack: done=%b stall=%b dout=%h, want 0 0 %h",
                             memDone, stall, dataMemOut, exp_dout);
                end
                @(posedge clk); #1;
                memAck = 1'b0;
            end
        end
    endtask

    task automatic test_back_to_back();
        int s1, s2, w1;
        w1 = int'($urandom_range(0, 3));
        run_access(1'b0, 16'($urandom) & 16'hFFFE, 16'h0, 16'($urandom), w1, s1);
        run_access(1'b1, 16'($urandom) & 16'hFFFE, 16'($urandom), 16'h0, 0, s2);
        checks++;
        if (s2 - s1 != w1 + 3) begin
            errors++;
            $display("FAIL back_to_back_spacing: got %0d, want %0d", s2 - s1, w1 + 3);
        end
    endtask

    task automatic test_halt();
        Halt = 1'b1; MemEN = 1'b1; MemWrite = 1'b0; addr = 16'h0100;
        @(negedge clk);
        checks++;
        if (stall !== 1'b0) begin
            errors++;
            $display("FAIL halt_priority_stall: got %b, want 0", stall);
        end
        @(posedge clk); #1;
        Halt = 1'b0;
        repeat (5) begin
            memAck = 1'($urandom);
            @(negedge clk);
            checks++;
            if (HaltOut !== 1'b1 || memReq !== 1'b0 || stall !== 1'b0 || memDone !== 1'b0) begin
                errors++;
                $display("FAIL halted_state: halt=%b req=%b stall=%b done=%b, want 1 0 0 0",
                         HaltOut, memReq, stall, memDone);
            end
            @(posedge clk); #1;
        end
        MemEN = 1'b0; memAck = 1'b0;
    endtask

    task automatic test_reset_mid_access();
        apply_reset();
        MemEN = 1'b1; MemWrite = 1'b0; addr = 16'h0200; Halt = 1'b0;
        @(posedge clk); #1;
        MemEN = 1'b0;
        checks++;
        if (memReq !== 1'b1) begin
            errors++;
            $display("FAIL mid_access_req: got %b, want 1", memReq);
        end
        #2 rst = 1'b0;
        exp_dout = '0; exp_err = 1'b0;
        #1;
        checks++;
        if (memReq !== 1'b0) begin
            errors++;
            $display("FAIL async_req_drop: got %b, want 0", memReq);
        end
        @(negedge clk) rst = 1'b1;
        @(posedge clk); #1;
        memAck = 1'b1; memRData = 16'hDEAD;
        repeat (2) begin
            @(negedge clk);
            checks++;
            if (memDone !== 1'b0 || memReq !== 1'b0 || stall !== 1'b0 || dataMemOut !== exp_dout) begin
                errors++;
                $display("FAIL stale_ack: done=%b req=%b stall=%b dout=%h, want 0 0 0 %h",
                         memDone, memReq, stall, dataMemOut, exp_dout);
            end
            @(posedge clk); #1;
            memAck = 1'b0;
        end
    endtask

    initial begin
        test_reset();
        test_zero_wait_load();
        test_store_then_load();
        test_misaligned();
        test_random();
        test_back_to_back();
        test_halt();
        test_reset_mid_access();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
